bcd_display_scan: RTL and testbench

- Reader side of the BCD time counters: takes the packed BCD digits produced by the seconds/minutes/hours counters and drives a time-multiplexed 7-segment display.
- Sits between the counter chain and the board's common-cathode/anode digit drivers.
- Provides a tear-free frame snapshot, leading-zero blanking, per-digit blink for time-setting, and a frame strobe.

---
 rtl/bcd_disp_pkg.sv | 28 ++
 rtl/bcd_to_seg7.sv | 27 ++
 rtl/bcd_display_scan.sv | 162 ++++++++++++++++
 tb/tb_bcd_display_scan.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_disp_pkg.sv
// Shared constants and helpers for the multiplexed BCD 7-segment display.
// Segment patterns are active-high with bit 6 = a ... bit 0 = g.
package bcd_disp_pkg;

    localparam logic [6:0] SEG_0    = 7'b1111110;
    localparam logic [6:0] SEG_1    = 7'b0110000;
    localparam logic [6:0] SEG_2    = 7'b1101101;
    localparam logic [6:0] SEG_3    = 7'b1111001;
    localparam logic [6:0] SEG_4    = 7'b0110011;
    localparam logic [6:0] SEG_5    = 7'b1011011;
    localparam logic [6:0] SEG_6    = 7'b1011111;
    localparam logic [6:0] SEG_7    = 7'b1110000;
    localparam logic [6:0] SEG_8    = 7'b1111111;
    localparam logic [6:0] SEG_9    = 7'b1111011;
    localparam logic [6:0] SEG_OFF  = 7'b0000000;
    localparam logic [6:0] SEG_DASH = 7'b0000001;

    // Ceiling log2, never less than 1 so single-value counters still get a bit.
    function automatic int unsigned idx_width(input int unsigned n);
        int unsigned w;
        w = 1;
        while ((64'd1 << w) < 64'(n)) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to 7-segment decoder; codes 10-15 show a dash.
module bcd_to_seg7
    import bcd_disp_pkg::*;
(
    input  logic [3:0] i_bcd,
    output logic [6:0] o_seg
);

    // Pattern lookup, invalid codes fall through to the dash.
    always_comb begin
        o_seg = SEG_DASH;
        case (i_bcd)
            4'd0:    o_seg = SEG_0;
            4'd1:    o_seg = SEG_1;
            4'd2:    o_seg = SEG_2;
            4'd3:    o_seg = SEG_3;
            4'd4:    o_seg = SEG_4;
            4'd5:    o_seg = SEG_5;
            4'd6:    o_seg = SEG_6;
            4'd7:    o_seg = SEG_7;
            4'd8:    o_seg = SEG_8;
            4'd9:    o_seg = SEG_9;
            default: o_seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/bcd_display_scan.sv
// Time-multiplexed 7-segment scanner for the BCD time counters.
// All state moves on the falling edge of CP, like the counter chain.
// The digits are snapshotted once per frame so a frame never shows a
// mix of old and new time values.
module bcd_display_scan
    import bcd_disp_pkg::*;
#(
    parameter int unsigned NDIG           = 6,
    parameter int unsigned SCAN_DIV       = 1000,
    parameter int unsigned BLINK_FRAMES   = 64,
    parameter bit          BLANK_LEAD     = 1'b1,
    parameter bit          SEG_ACTIVE_LOW = 1'b0,
    parameter bit          DIG_ACTIVE_LOW = 1'b0
) (
    input  logic              CP,
    input  logic              nCR,
    input  logic [4*NDIG-1:0] Digits,
    input  logic [NDIG-1:0]   DpMask,
    input  logic [NDIG-1:0]   Blink,
    output logic [6:0]        Seg,
    output logic              Dp,
    output logic [NDIG-1:0]   DigSel,
    output logic              FrameTick
);

    localparam int unsigned IW = idx_width(NDIG);
    localparam int unsigned PW = idx_width(SCAN_DIV);
    localparam int unsigned BW = idx_width(BLINK_FRAMES);

    localparam logic [IW-1:0] LAST_IDX   = IW'(NDIG - 1);
    localparam logic [PW-1:0] LAST_PRE   = PW'(SCAN_DIV - 1);
    localparam logic [BW-1:0] LAST_BLINK = BW'(BLINK_FRAMES - 1);

    localparam logic [6:0]      SEG_POL = {7{SEG_ACTIVE_LOW}};
    localparam logic [NDIG-1:0] DIG_POL = {NDIG{DIG_ACTIVE_LOW}};

    logic [PW-1:0]     r_pre_cnt;
    logic [IW-1:0]     r_idx;
    logic [BW-1:0]     r_blink_cnt;
    logic              r_blink_ph;
    logic              r_primed;
    logic [4*NDIG-1:0] r_sh_digits;
    logic [NDIG-1:0]   r_sh_dp;
    logic [NDIG-1:0]   r_sh_blink;
    logic              r_frame_tick;
    logic [6:0]        r_seg;
    logic              r_dp;
    logic [NDIG-1:0]   r_digsel;

    logic              w_tick;
    logic              w_wrap;
    logic [3:0]        w_cur_bcd;
    logic              w_cur_dp;
    logic              w_cur_blink;
    logic [NDIG-1:0]   w_onehot;
    logic [6:0]        w_dec_seg;
    logic              w_blank;
    logic              w_lead_blank;
    logic [6:0]        w_seg_nxt;
    logic              w_dp_nxt;

    // Scan stays frozen until the first snapshot is taken.
    assign w_tick = r_primed && (r_pre_cnt == LAST_PRE);
    assign w_wrap = w_tick && (r_idx == LAST_IDX);

    // Pick the active digit's shadow fields and build the one-hot select.
    always_comb begin
        w_cur_bcd   = 4'd0;
        w_cur_dp    = 1'b0;
        w_cur_blink = 1'b0;
        w_onehot    = '0;
        for (int unsigned i = 0; i < NDIG; i++) begin
            if (r_idx == IW'(i)) begin
                w_cur_bcd   = r_sh_digits[4*i +: 4];
                w_cur_dp    = r_sh_dp[i];
                w_cur_blink = r_sh_blink[i];
                w_onehot[i] = 1'b1;
            end
        end
    end

    bcd_to_seg7 u_dec (
        .i_bcd (w_cur_bcd),
        .o_seg (w_dec_seg)
    );

    // Blink blanks segments and point; leading-zero blanking keeps the point.
    always_comb begin
        w_blank      = r_blink_ph && w_cur_blink;
        w_lead_blank = BLANK_LEAD && (r_idx == LAST_IDX) && (w_cur_bcd == 4'd0);
        w_seg_nxt    = (w_blank || w_lead_blank) ? SEG_OFF : w_dec_seg;
        w_dp_nxt     = w_cur_dp && !w_blank;
    end

    // Prescaler and digit index.
    always_ff @(negedge CP or negedge nCR) begin
        if (!nCR) begin
            r_pre_cnt <= '0;
            r_idx     <= '0;
        end else if (r_primed) begin
            r_pre_cnt <= w_tick ? '0 : r_pre_cnt + 1'b1;
            if (w_tick) begin
                r_idx <= (r_idx == LAST_IDX) ? '0 : r_idx + 1'b1;
            end
        end
    end

    // Frame snapshot: first edge after reset, then every frame wrap.
    always_ff @(negedge CP or negedge nCR) begin
        if (!nCR) begin
            r_primed    <= 1'b0;
            r_sh_digits <= '0;
            r_sh_dp     <= '0;
            r_sh_blink  <= '0;
        end else begin
            r_primed <= 1'b1;
            if (!r_primed || w_wrap) begin
                r_sh_digits <= Digits;
                r_sh_dp     <= DpMask;
                r_sh_blink  <= Blink;
            end
        end
    end

    // Blink frame counter and phase; phase changes only on a frame wrap.
    always_ff @(negedge CP or negedge nCR) begin
        if (!nCR) begin
            r_blink_cnt <= '0;
            r_blink_ph  <= 1'b0;
        end else if (w_wrap) begin
            if (r_blink_cnt == LAST_BLINK) begin
                r_blink_cnt <= '0;
                r_blink_ph  <= ~r_blink_ph;
            end else begin
                r_blink_cnt <= r_blink_cnt + 1'b1;
            end
        end
    end

    // Output registers with polarity applied; held inactive until primed.
    always_ff @(negedge CP or negedge nCR) begin
        if (!nCR) begin
            r_seg        <= SEG_POL;
            r_dp         <= SEG_ACTIVE_LOW;
            r_digsel     <= DIG_POL;
            r_frame_tick <= 1'b0;
        end else begin
            r_frame_tick <= w_wrap;
            if (r_primed) begin
                r_seg    <= w_seg_nxt ^ SEG_POL;
                r_dp     <= w_dp_nxt ^ SEG_ACTIVE_LOW;
                r_digsel <= w_onehot ^ DIG_POL;
            end
        end
    end

    assign Seg       = r_seg;
    assign Dp        = r_dp;
    assign DigSel    = r_digsel;
    assign FrameTick = r_frame_tick;

endmodule

// File: tb/tb_bcd_display_scan.sv
// Directed bench for bcd_display_scan: vector table plus multi-cycle
// sequences for priming, frame strobe, tear-free snapshot, blink, reset.
module tb_bcd_display_scan;

    logic        CP;
    logic        nCR;
    logic [23:0] Digits;
    logic [5:0]  DpMask;
    logic [5:0]  Blink;

    logic [6:0] seg_a, seg_b, seg_c;
    logic       dp_a, dp_b, dp_c;
    logic [5:0] dig_a, dig_b, dig_c;
    logic       ft_a, ft_b, ft_c;

    int checks;
    int failures;

    bcd_display_scan #(.NDIG(6), .SCAN_DIV(4), .BLINK_FRAMES(2), .BLANK_LEAD(1'b1),
                       .SEG_ACTIVE_LOW(1'b0), .DIG_ACTIVE_LOW(1'b0)) dut (
        .CP(CP), .nCR(nCR), .Digits(Digits), .DpMask(DpMask), .Blink(Blink),
        .Seg(seg_a), .Dp(dp_a), .DigSel(dig_a), .FrameTick(ft_a));

    bcd_display_scan #(.NDIG(6), .SCAN_DIV(4), .BLINK_FRAMES(2), .BLANK_LEAD(1'b0),
                       .SEG_ACTIVE_LOW(1'b0), .DIG_ACTIVE_LOW(1'b0)) dut_nl (
        .CP(CP), .nCR(nCR), .Digits(Digits), .DpMask(DpMask), .Blink(Blink),
        .Seg(seg_b), .Dp(dp_b), .DigSel(dig_b), .FrameTick(ft_b));

    bcd_display_scan #(.NDIG(6), .SCAN_DIV(4), .BLINK_FRAMES(2), .BLANK_LEAD(1'b1),
                       .SEG_ACTIVE_LOW(1'b1), .DIG_ACTIVE_LOW(1'b1)) dut_inv (
        .CP(CP), .nCR(nCR), .Digits(Digits), .DpMask(DpMask), .Blink(Blink),
        .Seg(seg_c), .Dp(dp_c), .DigSel(dig_c), .FrameTick(ft_c));

    initial CP = 1'b1;
    always #5 CP = ~CP;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [23:0] digits;
        logic [5:0]  dpm;
        int          slot;
        logic [6:0]  seg;
        logic [6:0]  seg_nl;
        logic        dp;
    } vec_t;

    vec_t vecs[17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance n falling edges, then settle 2 time units past the edge.
    task automatic step(input int n);
        repeat (n) @(negedge CP);
        #2;
    endtask

    task automatic reset_release();
        nCR = 1'b0;
        step(1);
        nCR = 1'b1;
    endtask

    function automatic logic [6:0] seg_ref(input logic [3:0] d);
        case (d)
            4'd0: return 7'b1111110;
            4'd1: return 7'b0110000;
            4'd2: return 7'b1101101;
            4'd3: return 7'b1111001;
            4'd4: return 7'b0110011;
            4'd5: return 7'b1011011;
            4'd6: return 7'b1011111;
            4'd7: return 7'b1110000;
            4'd8: return 7'b1111111;
            4'd9: return 7'b1111011;
            default: return 7'b0000001;
        endcase
    endfunction

    initial begin
        logic [6:0]  inv_seg;
        logic [5:0]  oh, inv_oh;
        logic [23:0] d;
        logic [6:0]  exp_seg;
        int          cur, tgt;
        bit          lit;

        checks   = 0;
        failures = 0;
        nCR      = 1'b0;
        Digits   = 24'h235959;
        DpMask   = '0;
        Blink    = '0;

        vecs[0]  = '{24'h235959, 6'h00, 0, 7'b1111011, 7'b1111011, 1'b0};
        vecs[1]  = '{24'h235959, 6'h00, 1, 7'b1011011, 7'b1011011, 1'b0};
        vecs[2]  = '{24'h235959, 6'h00, 4, 7'b1111001, 7'b1111001, 1'b0};
        vecs[3]  = '{24'h235959, 6'h00, 5, 7'b1101101, 7'b1101101, 1'b0};
        vecs[4]  = '{24'h075959, 6'h00, 5, 7'b0000000, 7'b1111110, 1'b0};
        vecs[5]  = '{24'h075959, 6'h00, 4, 7'b1110000, 7'b1110000, 1'b0};
        vecs[6]  = '{24'h12345C, 6'h01, 0, 7'b0000001, 7'b0000001, 1'b1};
        vecs[7]  = '{24'h12345C, 6'h01, 1, 7'b1011011, 7'b1011011, 1'b0};
        vecs[8]  = '{24'h087614, 6'h20, 5, 7'b0000000, 7'b1111110, 1'b1};
        vecs[9]  = '{24'h087614, 6'h00, 2, 7'b1011111, 7'b1011111, 1'b0};
        vecs[10] = '{24'h087614, 6'h00, 3, 7'b1110000, 7'b1110000, 1'b0};
        vecs[11] = '{24'h087614, 6'h00, 1, 7'b0110000, 7'b0110000, 1'b0};
        vecs[12] = '{24'h087614, 6'h00, 4, 7'b1111111, 7'b1111111, 1'b0};
        vecs[13] = '{24'h087614, 6'h00, 0, 7'b0110011, 7'b0110011, 1'b0};
        vecs[14] = '{24'h100000, 6'h00, 0, 7'b1111110, 7'b1111110, 1'b0};
        vecs[15] = '{24'hF00000, 6'h00, 5, 7'b0000001, 7'b0000001, 1'b0};
        vecs[16] = '{24'h235959, 6'h3F, 4, 7'b1111001, 7'b1111001, 1'b1};

        // Reset state while nCR is held low.
        step(2);
        chk("rst seg", 32'(seg_a), 32'h00);
        chk("rst dp", 32'(dp_a), 32'h0);
        chk("rst digsel", 32'(dig_a), 32'h00);
        chk("rst frametick", 32'(ft_a), 32'h0);
        chk("rst inv seg", 32'(seg_c), 32'h7F);
        chk("rst inv dp", 32'(dp_c), 32'h1);
        chk("rst inv digsel", 32'(dig_c), 32'h3F);

        // Table: fresh reset per vector, then sample the requested slot.
        for (int i = 0; i < 17; i++) begin
            Digits = vecs[i].digits;
            DpMask = vecs[i].dpm;
            Blink  = '0;
            reset_release();
            step(2 + 4 * vecs[i].slot);
            oh      = 6'b000001 << vecs[i].slot;
            inv_oh  = ~oh;
            inv_seg = ~vecs[i].seg;
            chk($sformatf("vec%0d seg", i), 32'(seg_a), 32'(vecs[i].seg));
            chk($sformatf("vec%0d dp", i), 32'(dp_a), 32'(vecs[i].dp));
            chk($sformatf("vec%0d digsel", i), 32'(dig_a), 32'(oh));
            chk($sformatf("vec%0d nolead seg", i), 32'(seg_b), 32'(vecs[i].seg_nl));
            chk($sformatf("vec%0d inv seg", i), 32'(seg_c), 32'(inv_seg));
            chk($sformatf("vec%0d inv digsel", i), 32'(dig_c), 32'(inv_oh));
            chk($sformatf("vec%0d inv dp", i), 32'(dp_c), 32'(!vecs[i].dp));
        end

        // Priming edge, then per-cycle slot hold and frame strobe timing.
        Digits = 24'h235959;
        DpMask = '0;
        Blink  = '0;
        reset_release();
        step(1);
        chk("prime digsel", 32'(dig_a), 32'h00);
        chk("prime seg", 32'(seg_a), 32'h00);
        for (int e = 2; e <= 49; e++) begin
            step(1);
            oh = 6'b000001 << (((e - 2) / 4) % 6);
            chk($sformatf("scan e%0d digsel", e), 32'(dig_a), 32'(oh));
            chk($sformatf("scan e%0d frametick", e), 32'(ft_a), 32'((e == 25) || (e == 49)));
        end

        // Tear-free: input change during slot 0 waits for the next frame.
        Digits = 24'h000009;
        reset_release();
        step(3);
        chk("tear slot0 old", 32'(seg_a), 32'(7'b1111011));
        Digits = 24'h000010;
        step(3);
        chk("tear slot1 old", 32'(seg_a), 32'(7'b1111110));
        step(16);
        chk("tear slot5 old", 32'(seg_a), 32'(7'b0000000));
        step(4);
        chk("tear slot0 new", 32'(seg_a), 32'(7'b1111110));
        step(4);
        chk("tear slot1 new", 32'(seg_a), 32'(7'b0110000));

        // Blink on digits 0-1: lit frames 0-1, blank frames 2-3, lit again frame 4.
        d      = 24'h235959;
        Digits = d;
        DpMask = 6'b000011;
        Blink  = 6'b000011;
        reset_release();
        step(2);
        cur = 2;
        for (int f = 0; f < 5; f++) begin
            for (int s = 0; s < 3; s++) begin
                tgt = 2 + 24 * f + 4 * s;
                step(tgt - cur);
                cur = tgt;
                lit = !((s < 2) && (f == 2 || f == 3));
                exp_seg = lit ? seg_ref(d[4*s +: 4]) : 7'b0000000;
                oh = 6'b000001 << s;
                chk($sformatf("blink f%0d s%0d seg", f, s), 32'(seg_a), 32'(exp_seg));
                chk($sformatf("blink f%0d s%0d dp", f, s), 32'(dp_a), 32'((s < 2) && lit));
                chk($sformatf("blink f%0d s%0d digsel", f, s), 32'(dig_a), 32'(oh));
            end
        end

        // Mid-scan asynchronous reset, then restart with a fresh snapshot.
        Digits = 24'h235959;
        DpMask = '0;
        Blink  = '0;
        reset_release();
        step(14);
        chk("midrst pre digsel", 32'(dig_a), 32'(6'b001000));
        #1;
        nCR = 1'b0;
        #1;
        chk("midrst async digsel", 32'(dig_a), 32'h00);
        chk("midrst async seg", 32'(seg_a), 32'h00);
        chk("midrst async inv digsel", 32'(dig_c), 32'h3F);
        Digits = 24'h111111;
        step(1);
        nCR = 1'b1;
        step(1);
        chk("midrst prime digsel", 32'(dig_a), 32'h00);
        step(1);
        chk("midrst slot0 digsel", 32'(dig_a), 32'(6'b000001));
        chk("midrst slot0 seg", 32'(seg_a), 32'(7'b0110000));
        chk("midrst frametick", 32'(ft_a), 32'h0);
        step(4);
        chk("midrst slot1 digsel", 32'(dig_a), 32'(6'b000010));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
